// File: rtl/ternary_neuron_pkg.sv
// rtl/ternary_neuron_pkg.sv - shared types and defaults for the ternary neuron accumulator
package ternary_neuron_pkg;

   localparam int ACC_W_DEFAULT      = 10;
   localparam int CHUNKS_MAX_DEFAULT = 16;
   localparam int CNT_W_DEFAULT      = 5;

   // Ternary activation code; 2'b10 is never produced.
   typedef logic [1:0] act_t;
   localparam act_t ACT_ZERO = 2'b00;
   localparam act_t ACT_POS  = 2'b01;
   localparam act_t ACT_NEG  = 2'b11;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } state_t;

endpackage

// File: rtl/tn_sat_addsub.sv
// rtl/tn_sat_addsub.sv - combinational signed acc + a - b with saturation
//
// Ports:
//   i_acc  signed accumulator value (ACC_W)
//   i_add  unsigned count added (CNT_W)
//   i_sub  unsigned count subtracted (CNT_W)
//   o_sum  clamped signed result (ACC_W)
//   o_sat  result was clamped
module tn_sat_addsub #(
   parameter int ACC_W = 10,
   parameter int CNT_W = 5
) (
   input  logic [ACC_W-1:0] i_acc,
   input  logic [CNT_W-1:0] i_add,
   input  logic [CNT_W-1:0] i_sub,
   output logic [ACC_W-1:0] o_sum,
   output logic             o_sat
);

   localparam logic [ACC_W-1:0] MAX_POS = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] MIN_NEG = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] w_ext;
   logic           w_ovf;

   // One guard bit is enough: |add - sub| <= 2^CNT_W - 1 stays well inside
   // the extra range as long as ACC_W >= 7.
   assign w_ext = {i_acc[ACC_W-1], i_acc}
                + {{(ACC_W+1-CNT_W){1'b0}}, i_add}
                - {{(ACC_W+1-CNT_W){1'b0}}, i_sub};

   // Guard bit disagreeing with the sign bit means the true result left the ACC_W range.
   assign w_ovf = w_ext[ACC_W] ^ w_ext[ACC_W-1];

   assign o_sum = w_ovf ? (w_ext[ACC_W] ? MIN_NEG : MAX_POS) : w_ext[ACC_W-1:0];
   assign o_sat = w_ovf;

endmodule

// File: rtl/ternary_neuron_accum.sv
// rtl/ternary_neuron_accum.sv - multi-beat signed accumulator with ternary thresholding
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     beat handshake, in_last marks the final beat
//   pos_count, neg_count  popcounts under +1 / -1 weights
//   thr_hi, thr_lo        signed thresholds, sampled with the last beat
//   out_valid/out_ready   result handshake
//   out_act               01 = +1, 11 = -1, 00 = 0
//   out_sum               final signed sum
//   out_sat, out_err      saturation seen / too many beats
module ternary_neuron_accum
   import ternary_neuron_pkg::*;
#(
   parameter int ACC_W      = ACC_W_DEFAULT,
   parameter int CHUNKS_MAX = CHUNKS_MAX_DEFAULT,
   parameter int CNT_W      = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_last,
   input  logic [CNT_W-1:0] pos_count,
   input  logic [CNT_W-1:0] neg_count,
   input  logic [ACC_W-1:0] thr_hi,
   input  logic [ACC_W-1:0] thr_lo,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_act,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_sat,
   output logic             out_err
);

   // Counter must hold CHUNKS_MAX+1 so an overlong evaluation stays visible.
   localparam int              CB_W   = $clog2(CHUNKS_MAX + 2);
   localparam logic [CB_W-1:0] C_MAX  = CB_W'(CHUNKS_MAX);
   localparam logic [CB_W-1:0] C_TOP  = CB_W'(CHUNKS_MAX + 1);

   state_t           r_state;
   logic [ACC_W-1:0] r_acc;
   logic [CB_W-1:0]  r_beats;
   logic             r_sat;
   logic             r_err;
   act_t             r_out_act;
   logic [ACC_W-1:0] r_out_sum;
   logic             r_out_sat;
   logic             r_out_err;

   logic [ACC_W-1:0] w_acc_next;
   logic             w_clamped;
   logic             w_sat_next;
   logic             w_err_next;
   act_t             w_act;

   tn_sat_addsub #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_addsub (
      .i_acc (r_acc),
      .i_add (pos_count),
      .i_sub (neg_count),
      .o_sum (w_acc_next),
      .o_sat (w_clamped)
   );

   assign w_sat_next = r_sat | w_clamped;
   assign w_err_next = r_err | (r_beats == C_MAX);

   // Upper threshold is tested first so +1 wins when the thresholds overlap.
   always_comb begin
      w_act = ACT_ZERO;
      if ($signed(w_acc_next) > $signed(thr_hi)) begin
         w_act = ACT_POS;
      end else if ($signed(w_acc_next) < $signed(thr_lo)) begin
         w_act = ACT_NEG;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ACCUM;
         r_acc     <= '0;
         r_beats   <= '0;
         r_sat     <= 1'b0;
         r_err     <= 1'b0;
         r_out_act <= ACT_ZERO;
         r_out_sum <= '0;
         r_out_sat <= 1'b0;
         r_out_err <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (in_valid) begin
                  r_acc <= w_acc_next;
                  r_sat <= w_sat_next;
                  r_err <= w_err_next;
                  if (r_beats != C_TOP) begin
                     r_beats <= r_beats + CB_W'(1);
                  end
                  if (in_last) begin
                     r_out_act <= w_act;
                     r_out_sum <= w_acc_next;
                     r_out_sat <= w_sat_next;
                     r_out_err <= w_err_next;
                     r_state   <= DONE;
                  end
               end
            end
            DONE: begin
               // Result registers keep their values; only the evaluation state is cleared.
               if (out_ready) begin
                  r_acc   <= '0;
                  r_beats <= '0;
                  r_sat   <= 1'b0;
                  r_err   <= 1'b0;
                  r_state <= ACCUM;
               end
            end
            default: r_state <= ACCUM;
         endcase
      end
   end

   assign in_ready  = (r_state == ACCUM);
   assign out_valid = (r_state == DONE);
   assign out_act   = r_out_act;
   assign out_sum   = r_out_sum;
   assign out_sat   = r_out_sat;
   assign out_err   = r_out_err;

endmodule

// File: doc/ternary_neuron_accum.md
Name: ternary_neuron_accum

Overview:
- Sequential stage directly downstream of the 22-input popcount circuits.
- Each beat delivers two 5-bit counts from the same 22-input chunk:
  - pos_count: popcount of the inputs under +1 weights.
  - neg_count: popcount of the inputs under -1 weights.
- Accumulates the signed difference (pos_count - neg_count) over a multi-beat neuron evaluation.
- On the last beat, applies two thresholds, emits a ternary activation plus diagnostics, and holds the result under a valid/ready handshake.

Parameters:
- ACC_W, 10: signed accumulator and threshold width in bits; minimum 7.
- CHUNKS_MAX, 16: maximum legal beats per neuron evaluation.
- CNT_W, 5: width of pos_count and neg_count.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  beat offered.
- in_ready  out  1  beat can be accepted.
- in_last  in  1  final beat of the current neuron.
- pos_count  in  CNT_W  unsigned count; approximate circuits may emit any value 0..31.
- neg_count  in  CNT_W  unsigned count, same range as pos_count.
- thr_hi  in  ACC_W  signed upper threshold; sampled on the accepted last beat.
- thr_lo  in  ACC_W  signed lower threshold; sampled on the accepted last beat.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_act  out  2  activation: 01 = +1, 11 = -1, 00 = 0; 10 is never driven.
- out_sum  out  ACC_W  final signed accumulated sum.
- out_sat  out  1  accumulator saturated at least once during this evaluation.
- out_err  out  1  more than CHUNKS_MAX beats were accepted before the last beat.

Behaviour:
- Reset (asynchronous, rst_n low):
  - state = ACCUM.
  - acc, beat counter, sat flag, err flag all 0.
  - out_valid = 0, out_act = 00, out_sum = 0, out_sat = 0, out_err = 0.
  - in_ready becomes 1 right after reset release.
- States: ACCUM and DONE.
- ACCUM state:
  - in_ready = 1; out_valid = 0.
  - A beat is accepted when in_valid & in_ready.
  - On acceptance: acc_next = sat(acc + zext(pos_count) - zext(neg_count)), computed at ACC_W+1 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Clamping sets the sat flag (sticky for this evaluation).
  - The beat counter increments and saturates at CHUNKS_MAX+1.
  - If the counter is already CHUNKS_MAX when a beat is accepted, the err flag is set.
  - Accepting the last beat is not an error when it is beat number CHUNKS_MAX.
- Accepted beat with in_last = 1:
  - The same edge registers out_sum = acc_next and out_sat/out_err, including any contribution from this beat.
  - Activation from acc_next: +1 if acc_next > thr_hi; else -1 if acc_next < thr_lo; else 0.
  - +1 has priority when thr_lo > thr_hi.
  - State moves to DONE; out_valid rises on the next cycle. Latency from the last beat to out_valid is 1 cycle.
- DONE state:
  - in_ready = 0; outputs are held stable while out_valid & !out_ready.
  - On out_valid & out_ready: next state ACCUM; acc, counter and flags are cleared; out_valid falls.
  - Output registers keep their last values, but are don't-care while out_valid = 0.
- Throughput: N beats per neuron take N+1 cycles minimum, because the handshake cycle is a bubble.
- in_valid while in DONE is ignored and not consumed. Upstream must hold the beat.
- Single-beat neuron (in_last on the first beat) is legal.
- pos_count = neg_count = 0 is legal and leaves acc unchanged.
- Reset mid-evaluation or in DONE discards all state immediately; no partial result is emitted.

Decomposition:
- Package ternary_neuron_pkg holds:
  - act_t encoding constants ACT_ZERO = 00, ACT_POS = 01, ACT_NEG = 11.
  - State enum {ACCUM, DONE}.
  - Default ACC_W and CHUNKS_MAX.
- Sub-module tn_sat_addsub: combinational acc + a - b with signed saturation. Outputs the result and a sat flag; parameterised by ACC_W and CNT_W.
- The popcount circuits stay outside this block and are instantiated by the neuron top.

Test Plan:
- 3 beats (pos, neg) = (10,2), (5,5), (0,4) with last on beat 3, thr_hi = 3, thr_lo = -3 -> out_sum = 4, out_act = 01, out_sat = 0, out_err = 0; out_valid exactly 1 cycle after the last beat.
- Single beat (2,9), last, thr_hi = 0, thr_lo = -5 -> out_sum = -7, out_act = 11. Repeat with (4,4) -> out_sum = 0, out_act = 00.
- ACC_W = 7: 5 beats (31,0), last on beat 5 -> out_sum = 63, out_sat = 1. Next neuron, single beat (1,0) -> out_sum = 1, out_sat = 0 (flags cleared).
- 17 beats of (1,0) with CHUNKS_MAX = 16, last on beat 17 -> out_err = 1, out_sum = 17. Exactly 16 beats -> out_err = 0.
- Hold out_ready = 0 for 5 cycles in DONE while in_valid = 1 -> outputs stable, in_ready = 0, no beat consumed. Then out_ready = 1 -> ACCUM on the next cycle, and the held beat is accepted there.
- Assert rst_n low after 2 of 4 beats -> all outputs read 0 immediately. The next evaluation starts from acc = 0.
